// File: rtl/fifo_pkg.sv
// Shared definitions for the read side of the FIFO: default word width and
// the occupancy states of the output stream buffer.
package fifo_pkg;

    localparam int DATA_WIDTH_DEFAULT = 8;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } rd_state_e;

endpackage

// File: rtl/rd_stream_out.sv
// Read-side FIFO to valid/ready stream adapter with a 2-entry skid buffer
// and a registered handshake counter.
module rd_stream_out
    import fifo_pkg::*;
#(
    parameter int DataWidth = DATA_WIDTH_DEFAULT
) (
    input  logic                 rclk,
    input  logic                 rrst_n,
    input  logic                 rempty_i,
    input  logic [DataWidth-1:0] rdata_i,
    output logic                 rinc_o,
    input  logic                 rflush_i,
    output logic                 m_valid_o,
    input  logic                 m_ready_i,
    output logic [DataWidth-1:0] m_data_o,
    output logic [15:0]          rcount_o
);

    // Stream handshake: a beat transfers on any rclk edge where m_valid_o and
    // m_ready_i are both high; once valid, m_data_o holds until that edge.

    rd_state_e            state, state_n;
    logic [DataWidth-1:0] entry0, entry0_n;
    logic [DataWidth-1:0] entry1, entry1_n;
    logic [15:0]          rcount, rcount_n;
    logic                 push, pop;

    // rrst_n is folded in so no pop request escapes while reset is held.
    assign rinc_o    = rrst_n && !rempty_i && (state != TWO) && !rflush_i;
    assign push      = rinc_o;
    assign m_valid_o = (state != EMPTY);
    assign m_data_o  = entry0;
    assign rcount_o  = rcount;
    assign pop       = m_valid_o && m_ready_i;

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            state  <= EMPTY;
            entry0 <= '0;
            entry1 <= '0;
            rcount <= '0;
        end else begin
            state  <= state_n;
            entry0 <= entry0_n;
            entry1 <= entry1_n;
            rcount <= rcount_n;
        end
    end

    always_comb begin
        state_n  = state;
        entry0_n = entry0;
        entry1_n = entry1;
        rcount_n = rcount + {15'd0, pop};

        case (state)
            EMPTY: begin
                if (push) begin
                    state_n  = ONE;
                    entry0_n = rdata_i;
                end
            end
            ONE: begin
                if (push && pop) begin
                    entry0_n = rdata_i;
                end else if (push) begin
                    state_n  = TWO;
                    entry1_n = rdata_i;
                end else if (pop) begin
                    state_n  = EMPTY;
                end
            end
            TWO: begin
                if (pop) begin
                    state_n  = ONE;
                    entry0_n = entry1;
                end
            end
            default: state_n = EMPTY;
        endcase

        // Flush discards the buffer but the counter above still sees the beat.
        if (rflush_i) begin
            state_n = EMPTY;
        end
    end

endmodule

// File: tb/tb_rd_stream_out.sv
// Directed bench for rd_stream_out: a queue stands in for the FIFO memory and
// a scoreboard checks every delivered beat against the expected order.
module tb_rd_stream_out;

    localparam int W = 8;

    logic         rclk;
    logic         rrst_n;
    logic         rempty_i;
    logic [W-1:0] rdata_i;
    logic         rinc_o;
    logic         rflush_i;
    logic         m_valid_o;
    logic         m_ready_i;
    logic [W-1:0] m_data_o;
    logic [15:0]  rcount_o;

    logic [W-1:0] fifo_q[$];
    logic [W-1:0] exp_q[$];

    int n_checks = 0;
    int n_fail   = 0;
    int push_cnt = 0;
    int pop_cnt  = 0;
    int cyc      = 0;
    int first_pop_cyc = -1;
    int last_pop_cyc  = -1;

    rd_stream_out #(.DataWidth(W)) dut (
        .rclk      (rclk),
        .rrst_n    (rrst_n),
        .rempty_i  (rempty_i),
        .rdata_i   (rdata_i),
        .rinc_o    (rinc_o),
        .rflush_i  (rflush_i),
        .m_valid_o (m_valid_o),
        .m_ready_i (m_ready_i),
        .m_data_o  (m_data_o),
        .rcount_o  (rcount_o)
    );

    // clock
    initial rclk = 1'b0;
    always #5 rclk = ~rclk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_fifo();
        rempty_i = (fifo_q.size() == 0);
        rdata_i  = (fifo_q.size() != 0) ? fifo_q[0] : '0;
        #1;
    endtask

    // One rclk cycle: sample the handshake at the falling edge, then apply the
    // pop to the model FIFO and score the delivered beat after the rising edge.
    task automatic tick();
        logic         p, q;
        logic [W-1:0] d;
        @(negedge rclk);
        p = rinc_o;
        q = m_valid_o && m_ready_i;
        d = m_data_o;
        @(posedge rclk);
        #1;
        cyc++;
        if (p) begin
            if (fifo_q.size() != 0) void'(fifo_q.pop_front());
            push_cnt++;
        end
        if (q) begin
            pop_cnt++;
            if (first_pop_cyc < 0) first_pop_cyc = cyc;
            last_pop_cyc = cyc;
            check("beat_expected", {31'd0, exp_q.size() != 0}, 32'd1);
            if (exp_q.size() != 0) check("beat_data", {24'd0, d}, {24'd0, exp_q.pop_front()});
        end
        drive_fifo();
    endtask

    task automatic reset_counts();
        push_cnt = 0;
        pop_cnt  = 0;
        first_pop_cyc = -1;
        last_pop_cyc  = -1;
    endtask

    initial begin
        int guard;

        // reset with FIFO non-empty
        rrst_n    = 1'b0;
        rflush_i  = 1'b0;
        m_ready_i = 1'b1;
        fifo_q.push_back(8'h99);
        drive_fifo();
        check("rst_rinc",   {31'd0, rinc_o},    32'd0);
        check("rst_valid",  {31'd0, m_valid_o}, 32'd0);
        check("rst_count",  {16'd0, rcount_o},  32'd0);
        check("rst_data",   {24'd0, m_data_o},  32'd0);
        @(posedge rclk); @(posedge rclk); #1;
        check("rst_rinc_hold",  {31'd0, rinc_o},    32'd0);
        check("rst_valid_hold", {31'd0, m_valid_o}, 32'd0);
        fifo_q.delete();
        drive_fifo();
        rrst_n = 1'b1;
        tick();

        // streaming 0x01..0x08
        reset_counts();
        for (int i = 1; i <= 8; i++) begin
            fifo_q.push_back(W'(i));
            exp_q.push_back(W'(i));
        end
        drive_fifo();
        check("stream_rinc_first", {31'd0, rinc_o}, 32'd1);
        for (int i = 0; i < 12; i++) tick();
        check("stream_pushes",  push_cnt, 32'd8);
        check("stream_pops",    pop_cnt,  32'd8);
        check("stream_consec",  last_pop_cyc - first_pop_cyc, 32'd7);
        check("stream_count",   {16'd0, rcount_o}, 32'd8);
        check("stream_sb_left", exp_q.size(), 32'd0);

        // backpressure A0..A2
        reset_counts();
        m_ready_i = 1'b0;
        fifo_q.push_back(8'hA0); fifo_q.push_back(8'hA1); fifo_q.push_back(8'hA2);
        exp_q.push_back(8'hA0); exp_q.push_back(8'hA1); exp_q.push_back(8'hA2);
        drive_fifo();
        tick(); tick();
        for (int i = 0; i < 3; i++) begin
            check("bp_rinc_full", {31'd0, rinc_o},    32'd0);
            check("bp_empty_in",  {31'd0, rempty_i},  32'd0);
            check("bp_valid",     {31'd0, m_valid_o}, 32'd1);
            check("bp_data_hold", {24'd0, m_data_o},  32'hA0);
            tick();
        end
        check("bp_pushes_held", push_cnt, 32'd2);
        m_ready_i = 1'b1;
        #1;
        for (int i = 0; i < 5; i++) tick();
        check("bp_pops",    pop_cnt, 32'd3);
        check("bp_sb_left", exp_q.size(), 32'd0);
        check("bp_count",   {16'd0, rcount_o}, 32'd11);
        check("bp_valid_end", {31'd0, m_valid_o}, 32'd0);

        // empty boundary: single word
        reset_counts();
        fifo_q.push_back(8'h5A);
        exp_q.push_back(8'h5A);
        drive_fifo();
        for (int i = 0; i < 4; i++) tick();
        check("eb_pushes",  push_cnt, 32'd1);
        check("eb_pops",    pop_cnt,  32'd1);
        check("eb_valid",   {31'd0, m_valid_o}, 32'd0);
        check("eb_rinc",    {31'd0, rinc_o},    32'd0);
        check("eb_count",   {16'd0, rcount_o},  32'd12);

        // flush from TWO
        reset_counts();
        m_ready_i = 1'b0;
        fifo_q.push_back(8'h11); fifo_q.push_back(8'h22); fifo_q.push_back(8'h33);
        exp_q.push_back(8'h33);
        drive_fifo();
        tick(); tick();
        check("fl_full_valid", {31'd0, m_valid_o}, 32'd1);
        check("fl_full_data",  {24'd0, m_data_o},  32'h11);
        rflush_i = 1'b1;
        #1;
        check("fl_rinc_supp", {31'd0, rinc_o}, 32'd0);
        tick();
        rflush_i = 1'b0;
        #1;
        check("fl_valid_after", {31'd0, m_valid_o}, 32'd0);
        m_ready_i = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) tick();
        check("fl_pops",    pop_cnt, 32'd1);
        check("fl_sb_left", exp_q.size(), 32'd0);
        check("fl_count",   {16'd0, rcount_o}, 32'd13);

        // reset mid-transfer drops buffered words
        m_ready_i = 1'b0;
        fifo_q.push_back(8'h77); fifo_q.push_back(8'h88);
        drive_fifo();
        tick(); tick();
        rrst_n = 1'b0;
        #1;
        check("mr_valid", {31'd0, m_valid_o}, 32'd0);
        check("mr_rinc",  {31'd0, rinc_o},    32'd0);
        check("mr_count", {16'd0, rcount_o},  32'd0);
        @(posedge rclk); #1;
        rrst_n = 1'b1;
        fifo_q.delete();
        drive_fifo();
        tick();
        check("mr_valid_post", {31'd0, m_valid_o}, 32'd0);

        // counter wrap after 65536 handshakes
        reset_counts();
        m_ready_i = 1'b1;
        for (int i = 0; i < 65536; i++) begin
            fifo_q.push_back(W'(i));
            exp_q.push_back(W'(i));
        end
        drive_fifo();
        guard = 0;
        while (pop_cnt < 65535 && guard < 70000) begin
            tick();
            guard++;
        end
        check("wrap_reached_ffff", {31'd0, pop_cnt == 65535}, 32'd1);
        check("wrap_ffff", {16'd0, rcount_o}, 32'hFFFF);
        guard = 0;
        while (pop_cnt < 65536 && guard < 8) begin
            tick();
            guard++;
        end
        check("wrap_reached_all", {31'd0, pop_cnt == 65536}, 32'd1);
        check("wrap_zero",    {16'd0, rcount_o}, 32'h0000);
        check("wrap_sb_left", exp_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rd_stream_out.md
RD_STREAM_OUT -- requirements
Module: rd_stream_out

Interface
REQ-001 SHALL have parameter DataWidth, default 8, width of FIFO word and stream data.
REQ-002 SHALL have port rclk  input  1  read-domain clock; all state changes on its rising edge.
REQ-003 SHALL have port rrst_n  input  1  reset; asynchronous, active-low.
REQ-004 SHALL have port rempty_i  input  1  FIFO empty flag from read-pointer/empty logic (rclk domain).
REQ-005 SHALL have port rdata_i  input  DataWidth  FIFO head word, combinational memory read at current read pointer; valid whenever rempty_i=0.
REQ-006 SHALL have port rinc_o  output  1  pop request to read-pointer logic; advances pointer at next rclk edge.
REQ-007 SHALL have port rflush_i  input  1  synchronous flush of internal buffer.
REQ-008 SHALL have port m_valid_o  output  1  stream data valid.
REQ-009 SHALL have port m_ready_i  input  1  downstream ready.
REQ-010 SHALL have port m_data_o  output  DataWidth  stream data, registered.
REQ-011 SHALL have port rcount_o  output  16  count of completed stream handshakes, registered.

Function
REQ-012 SHALL hold a 2-entry buffer (entry0 = head, entry1), state EMPTY/ONE/TWO = 0/1/2 words held.
REQ-013 SHALL drive rinc_o = !rempty_i && state!=TWO && !rflush_i, combinationally; push = rinc_o.
REQ-014 SHALL capture rdata_i on every push cycle; pushed word available on m_data_o no earlier than next cycle.
REQ-015 SHALL drive m_valid_o = (state!=EMPTY) and m_data_o = entry0, both direct from registers.
REQ-016 SHALL define pop = m_valid_o && m_ready_i; entry0 retires on that edge.
REQ-017 SHALL transition: EMPTY: push->ONE (entry0<=rdata_i).
REQ-018 SHALL transition: ONE: push&pop->ONE (entry0<=rdata_i); push only->TWO (entry1<=rdata_i); pop only->EMPTY.
REQ-019 SHALL transition: TWO: pop->ONE (entry0<=entry1); no push possible in TWO.
REQ-020 SHALL keep m_data_o stable while m_valid_o=1 and m_ready_i=0 (no data change without handshake).
REQ-021 SHALL sustain one word per cycle when rempty_i=0 and m_ready_i=1 continuously.
REQ-022 SHALL, on rflush_i=1, go to EMPTY at next edge, discard buffered words, suppress push; flush overrides simultaneous pop/push; rcount_o still counts a handshake occurring in the flush cycle.
REQ-023 SHALL increment rcount_o by 1 per pop, wrapping 0xFFFF->0x0000.
REQ-024 SHALL never read or push while rempty_i=1; words arriving after empty deasserts are delivered in FIFO order with no loss or duplication.

Reset
REQ-025 SHALL on rrst_n=0 immediately force state EMPTY, m_valid_o=0, rcount_o=0, entry0/entry1=0, rinc_o=0 (regardless of rempty_i).
REQ-026 SHALL, on reset mid-transfer, drop buffered words; first post-reset push occurs no earlier than first rclk edge after rrst_n rises.

Structure
REQ-027 SHALL take DataWidth default and the state enum (EMPTY, ONE, TWO) from shared package fifo_pkg.
REQ-028 SHALL be a single flat module; no sub-module is natural.

Verification
REQ-029 SHALL test reset: rrst_n low with rempty_i=0 -> rinc_o=0, m_valid_o=0, rcount_o=0 during reset.
REQ-030 SHALL test streaming: FIFO holds 0x01..0x08, m_ready_i=1 -> rinc_o high 8 cycles, m_data_o 0x01..0x08 on 8 consecutive cycles, rcount_o=8.
REQ-031 SHALL test backpressure: 3 words 0xA0,0xA1,0xA2, m_ready_i=0 -> state TWO, rinc_o=0, m_data_o=0xA0 stable; release ready -> 0xA0,0xA1,0xA2 in order.
REQ-032 SHALL test empty boundary: single word 0x5A then rempty_i=1 -> exactly one push, one beat 0x5A, m_valid_o=0 after.
REQ-033 SHALL test flush: state TWO (0x11,0x22), rflush_i=1 one cycle -> m_valid_o=0 next cycle, next delivered word is next FIFO word 0x33.
REQ-034 SHALL test counter wrap: preload via 65536 handshakes -> rcount_o returns to 0x0000.
